// File: rtl/bp_pkg.sv
// Shared helpers for the branch direction predictor.
//   clog2     : ceiling log2 used to size table indices
//   sat_inc   : saturating increment of a width-bit counter
//   sat_dec   : saturating decrement of a width-bit counter
//   bht_hash  : bimodal / gshare table index hash
package bp_pkg;

  // Ceiling log2; clog2(1) = 0.
  function automatic int unsigned clog2(input int unsigned value);
    int unsigned r;
    r = 0;
    for (int unsigned i = 0; i < 32; i++) begin
      if ((64'(1) << r) < 64'(value)) r = r + 1;
    end
    return r;
  endfunction

  // All-ones value of a width-bit counter.
  function automatic logic [31:0] cnt_max(input int unsigned width);
    return (width >= 32) ? 32'hFFFF_FFFF : ((32'(1) << width) - 32'd1);
  endfunction

  function automatic logic [31:0] sat_inc(input logic [31:0] cnt, input int unsigned width);
    return (cnt >= cnt_max(width)) ? cnt_max(width) : cnt + 32'd1;
  endfunction

  function automatic logic [31:0] sat_dec(input logic [31:0] cnt, input int unsigned width);
    return (cnt == 32'd0) ? 32'd0 : cnt - 32'd1;
  endfunction

  // History is zero-extended into the low index bits; ghr_w = 0 is pure bimodal.
  function automatic logic [31:0] bht_hash(input logic [31:0] pc_slice,
                                           input logic [31:0] ghr,
                                           input int unsigned ghr_w);
    return (ghr_w == 0) ? pc_slice : (pc_slice ^ ghr);
  endfunction

endpackage

// File: rtl/bht_sat_counter.sv
// One saturating direction counter of the branch history table.
//   clk, rst : clock and synchronous active-high reset
//   en       : apply an update this cycle
//   taken    : resolved direction (1 = count up, 0 = count down)
//   cnt_o    : registered counter value
module bht_sat_counter
  import bp_pkg::*;
#(
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned RESET_CNT = (2 ** CNT_W) - 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             taken,
  output logic [CNT_W-1:0] cnt_o
);

  // Counter register; reset takes priority over any pending update.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_o <= CNT_W'(RESET_CNT);
    end else if (en) begin
      if (taken) cnt_o <= CNT_W'(sat_inc(32'(cnt_o), CNT_W));
      else       cnt_o <= CNT_W'(sat_dec(32'(cnt_o), CNT_W));
    end
  end

endmodule

// File: rtl/branch_history_table.sv
// Branch direction predictor: table of saturating counters indexed by PC,
// optionally XOR-hashed with a non-speculative global history (gshare).
//   clk, rst            : clock and synchronous active-high reset
//   lookup_pc_i         : fetch PC
//   predict_taken_o     : MSB of the selected counter (combinational)
//   predict_idx_o       : index used for this lookup (combinational)
//   update_valid_i      : a conditional branch resolved this cycle
//   update_idx_i        : index captured at that branch's fetch
//   update_taken_i      : resolved direction
//   update_mispredict_i : resolved direction differed from prediction
//   ghr_o               : current global history (0 when GHR_W = 0)
//   mispredict_cnt_o    : saturating count of resolved mispredicts
module branch_history_table
  import bp_pkg::*;
#(
  parameter int unsigned ENTRIES   = 64,
  parameter int unsigned CNT_W     = 2,
  parameter int unsigned PC_W      = 32,
  parameter int unsigned IDX_LSB   = 2,
  parameter int unsigned GHR_W     = 0,
  parameter int unsigned RESET_CNT = (2 ** CNT_W) - 1,
  localparam int unsigned IDX_W    = clog2(ENTRIES),
  localparam int unsigned GHR_OW   = (GHR_W > 0) ? GHR_W : 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [PC_W-1:0]   lookup_pc_i,
  output logic              predict_taken_o,
  output logic [IDX_W-1:0]  predict_idx_o,
  input  logic              update_valid_i,
  input  logic [IDX_W-1:0]  update_idx_i,
  input  logic              update_taken_i,
  input  logic              update_mispredict_i,
  output logic [GHR_OW-1:0] ghr_o,
  output logic [31:0]       mispredict_cnt_o
);

  logic [CNT_W-1:0]  cnt_arr [ENTRIES];
  logic [GHR_OW-1:0] ghr_q;
  logic [IDX_W-1:0]  pc_slice;
  logic              unused_pc;

  assign pc_slice  = lookup_pc_i[IDX_LSB +: IDX_W];
  assign unused_pc = ^lookup_pc_i;

  // Counter array; each entry updates only when the resolved index selects it.
  for (genvar e = 0; e < ENTRIES; e++) begin : g_entry
    bht_sat_counter #(
      .CNT_W     (CNT_W),
      .RESET_CNT (RESET_CNT)
    ) u_cnt (
      .clk   (clk),
      .rst   (rst),
      .en    (update_valid_i && (update_idx_i == IDX_W'(e))),
      .taken (update_taken_i),
      .cnt_o (cnt_arr[e])
    );
  end

  // Global history shifts in the resolved direction, oldest bit falls off the top.
  if (GHR_W > 0) begin : g_ghr
    always_ff @(posedge clk) begin
      if (rst) begin
        ghr_q <= '0;
      end else if (update_valid_i) begin
        ghr_q <= GHR_OW'({ghr_q, update_taken_i});
      end
    end
  end else begin : g_no_ghr
    assign ghr_q = '0;
  end

  assign ghr_o = ghr_q;

  // Same-cycle lookup reads the flop array directly, so it sees pre-update values.
  assign predict_idx_o   = IDX_W'(bht_hash(32'(pc_slice), 32'(ghr_q), GHR_W));
  assign predict_taken_o = cnt_arr[predict_idx_o][CNT_W-1];

  // Mispredict counter, sticky at all-ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      mispredict_cnt_o <= '0;
    end else if (update_valid_i && update_mispredict_i && (mispredict_cnt_o != 32'hFFFF_FFFF)) begin
      mispredict_cnt_o <= mispredict_cnt_o + 32'd1;
    end
  end

endmodule

// File: tb/tb_branch_history_table.sv
// Directed bench: a default bimodal table, a GHR_W=4 gshare table and a
// CNT_W=3 table share clock, reset and update inputs.
module tb_branch_history_table;

  logic        clk;
  logic        rst;
  logic [31:0] lookup_pc;
  logic        update_valid;
  logic [5:0]  update_idx;
  logic        update_taken;
  logic        update_mispredict;

  logic        d_pred, g_pred, w_pred;
  logic [5:0]  d_idx, g_idx, w_idx;
  logic [0:0]  d_ghr, w_ghr;
  logic [3:0]  g_ghr;
  logic [31:0] d_mis, g_mis, w_mis;

  int pass_cnt  = 0;
  int check_cnt = 0;

  branch_history_table dut_d (
    .clk(clk), .rst(rst), .lookup_pc_i(lookup_pc),
    .predict_taken_o(d_pred), .predict_idx_o(d_idx),
    .update_valid_i(update_valid), .update_idx_i(update_idx),
    .update_taken_i(update_taken), .update_mispredict_i(update_mispredict),
    .ghr_o(d_ghr), .mispredict_cnt_o(d_mis)
  );

  branch_history_table #(.GHR_W(4)) dut_g (
    .clk(clk), .rst(rst), .lookup_pc_i(lookup_pc),
    .predict_taken_o(g_pred), .predict_idx_o(g_idx),
    .update_valid_i(update_valid), .update_idx_i(update_idx),
    .update_taken_i(update_taken), .update_mispredict_i(update_mispredict),
    .ghr_o(g_ghr), .mispredict_cnt_o(g_mis)
  );

  branch_history_table #(.CNT_W(3)) dut_w (
    .clk(clk), .rst(rst), .lookup_pc_i(lookup_pc),
    .predict_taken_o(w_pred), .predict_idx_o(w_idx),
    .update_valid_i(update_valid), .update_idx_i(update_idx),
    .update_taken_i(update_taken), .update_mispredict_i(update_mispredict),
    .ghr_o(w_ghr), .mispredict_cnt_o(w_mis)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic do_reset();
    rst = 1'b1;
    update_valid = 1'b0;
    update_mispredict = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
  endtask

  task automatic upd(input logic [5:0] idx, input logic tk, input logic mis);
    update_valid = 1'b1;
    update_idx = idx;
    update_taken = tk;
    update_mispredict = mis;
    @(posedge clk); #1;
    update_valid = 1'b0;
    update_mispredict = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    lookup_pc = 32'h40;
    #1;
    check_cnt++; if (d_pred !== 1'b1) $display("FAIL reset_pred got %0d want 1", d_pred); else pass_cnt++;
    check_cnt++; if (d_idx !== 6'd16) $display("FAIL reset_idx got %0d want 16", d_idx); else pass_cnt++;
    check_cnt++; if (d_ghr !== 1'b0) $display("FAIL reset_ghr got %0d want 0", d_ghr); else pass_cnt++;
    check_cnt++; if (d_mis !== 32'd0) $display("FAIL reset_mis got %0d want 0", d_mis); else pass_cnt++;
    check_cnt++; if (g_ghr !== 4'd0) $display("FAIL reset_gshare_ghr got %0d want 0", g_ghr); else pass_cnt++;
  endtask

  task automatic test_bimodal();
    logic exp_nt [4];
    logic exp_t  [2];
    exp_nt = '{1'b1, 1'b0, 1'b0, 1'b0};
    exp_t  = '{1'b0, 1'b1};
    lookup_pc = 32'h14;
    #1;
    check_cnt++; if (d_idx !== 6'd5) $display("FAIL bimodal_idx got %0d want 5", d_idx); else pass_cnt++;
    for (int i = 0; i < 4; i++) begin
      upd(6'd5, 1'b0, 1'b0);
      check_cnt++;
      if (d_pred !== exp_nt[i]) $display("FAIL bimodal_dec%0d got %0d want %0d", i, d_pred, exp_nt[i]);
      else pass_cnt++;
    end
    for (int i = 0; i < 2; i++) begin
      upd(6'd5, 1'b1, 1'b0);
      check_cnt++;
      if (d_pred !== exp_t[i]) $display("FAIL bimodal_inc%0d got %0d want %0d", i, d_pred, exp_t[i]);
      else pass_cnt++;
    end
  endtask

  // Counter at idx 5 is 2 on entry.
  task automatic test_same_cycle();
    lookup_pc = 32'h14;
    update_valid = 1'b1;
    update_idx = 6'd5;
    update_taken = 1'b0;
    update_mispredict = 1'b0;
    #1;
    check_cnt++; if (d_pred !== 1'b1) $display("FAIL same_cycle_pre got %0d want 1", d_pred); else pass_cnt++;
    @(posedge clk); #1;
    update_valid = 1'b0;
    #1;
    check_cnt++; if (d_pred !== 1'b0) $display("FAIL same_cycle_post got %0d want 0", d_pred); else pass_cnt++;
  endtask

  // 3-bit counter: 7 must hold under taken, then 7->6->5->4->3 flips the MSB.
  task automatic test_wide();
    do_reset();
    lookup_pc = 32'h14;
    for (int i = 0; i < 3; i++) begin
      upd(6'd5, 1'b1, 1'b0);
      check_cnt++; if (w_pred !== 1'b1) $display("FAIL wide_sat%0d got %0d want 1", i, w_pred); else pass_cnt++;
    end
    for (int i = 0; i < 3; i++) begin
      upd(6'd5, 1'b0, 1'b0);
      check_cnt++; if (w_pred !== 1'b1) $display("FAIL wide_dec%0d got %0d want 1", i, w_pred); else pass_cnt++;
    end
    upd(6'd5, 1'b0, 1'b0);
    check_cnt++; if (w_pred !== 1'b0) $display("FAIL wide_dec3 got %0d want 0", w_pred); else pass_cnt++;
  endtask

  task automatic test_gshare();
    do_reset();
    lookup_pc = 32'h40;
    upd(6'd0, 1'b1, 1'b0);
    check_cnt++; if (g_ghr !== 4'b0001) $display("FAIL gshare_ghr1 got %b want 0001", g_ghr); else pass_cnt++;
    upd(6'd0, 1'b0, 1'b0);
    upd(6'd0, 1'b1, 1'b0);
    upd(6'd0, 1'b1, 1'b0);
    check_cnt++; if (g_ghr !== 4'b1011) $display("FAIL gshare_ghr got %b want 1011", g_ghr); else pass_cnt++;
    check_cnt++; if (g_idx !== 6'd27) $display("FAIL gshare_idx got %0d want 27", g_idx); else pass_cnt++;
    check_cnt++; if (d_ghr !== 1'b0) $display("FAIL bimodal_ghr got %0d want 0", d_ghr); else pass_cnt++;
    check_cnt++; if (d_idx !== 6'd16) $display("FAIL bimodal_idx_nohash got %0d want 16", d_idx); else pass_cnt++;
  endtask

  // idx 7 goes 3->2->1->0->1; invalid cycles must not move anything.
  task automatic test_mispredict();
    do_reset();
    lookup_pc = 32'h1C;
    upd(6'd7, 1'b0, 1'b1);
    upd(6'd7, 1'b0, 1'b1);
    upd(6'd7, 1'b0, 1'b1);
    upd(6'd7, 1'b1, 1'b0);
    check_cnt++; if (d_mis !== 32'd3) $display("FAIL mis_cnt got %0d want 3", d_mis); else pass_cnt++;
    check_cnt++; if (d_pred !== 1'b0) $display("FAIL mis_pred got %0d want 0", d_pred); else pass_cnt++;
    check_cnt++; if (g_ghr !== 4'b0001) $display("FAIL mis_ghr got %b want 0001", g_ghr); else pass_cnt++;
    update_valid = 1'b0;
    update_idx = 6'd7;
    update_taken = 1'b1;
    update_mispredict = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    update_mispredict = 1'b0;
    check_cnt++; if (d_mis !== 32'd3) $display("FAIL idle_mis got %0d want 3", d_mis); else pass_cnt++;
    check_cnt++; if (d_pred !== 1'b0) $display("FAIL idle_pred got %0d want 0", d_pred); else pass_cnt++;
    check_cnt++; if (g_ghr !== 4'b0001) $display("FAIL idle_ghr got %b want 0001", g_ghr); else pass_cnt++;
  endtask

  // Runs on the state left by test_mispredict: mispredicts = 3, ghr nonzero.
  task automatic test_reset_vs_update();
    lookup_pc = 32'h24;
    upd(6'd9, 1'b0, 1'b0);
    upd(6'd9, 1'b0, 1'b0);
    upd(6'd9, 1'b0, 1'b0);
    check_cnt++; if (d_pred !== 1'b0) $display("FAIL pre_rst_pred got %0d want 0", d_pred); else pass_cnt++;
    check_cnt++; if (g_ghr !== 4'b1000) $display("FAIL pre_rst_ghr got %b want 1000", g_ghr); else pass_cnt++;
    rst = 1'b1;
    update_valid = 1'b1;
    update_idx = 6'd9;
    update_taken = 1'b0;
    update_mispredict = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    update_valid = 1'b0;
    update_mispredict = 1'b0;
    #1;
    check_cnt++; if (d_pred !== 1'b1) $display("FAIL rst_upd_pred got %0d want 1", d_pred); else pass_cnt++;
    check_cnt++; if (d_mis !== 32'd0) $display("FAIL rst_upd_mis got %0d want 0", d_mis); else pass_cnt++;
    check_cnt++; if (g_ghr !== 4'd0) $display("FAIL rst_upd_ghr got %b want 0000", g_ghr); else pass_cnt++;
  endtask

  initial begin
    rst = 1'b1;
    lookup_pc = 32'h0;
    update_valid = 1'b0;
    update_idx = 6'd0;
    update_taken = 1'b0;
    update_mispredict = 1'b0;
    test_reset();
    test_bimodal();
    test_same_cycle();
    test_wide();
    test_gshare();
    test_mispredict();
    test_reset_vs_update();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
